shifter_arbiter: RTL and testbench
==================================

Name: shifter_arbiter

Overview:
- Shares one pipelined 32-bit barrel shifter (`shifter`: data, shift amount, rotate flag, registered result) between NREQ independent requesters.
- Performs round-robin arbitration with a valid/ready handshake on each requester port and issues at most one operation per cycle.
- Tracks each in-flight operation's requester ID through a tag pipeline matched to the shifter latency, and returns each result tagged with that ID.
- Sits between the requesting units and the shifter; the shifter is instantiated alongside this block, not inside it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, data width.
- SW, 5, shift-amount width (log2 W).
- LAT, 5, shifter latency in clk cycles from sh_* inputs to a valid sh_out (≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*W  packed operands; requester i occupies bits [i*W +: W].
- req_shift  in  NREQ*SW  packed shift amounts.
- req_rot  in  NREQ  per-requester rotate flag (1 = rotate left, 0 = logical shift left).
- sh_a  out  W  operand to the shifter.
- sh_shift  out  SW  shift amount to the shifter.
- sh_rot  out  1  rotate flag to the shifter.
- sh_out  in  W  shifter result.
- rsp_valid  out  1  response valid for exactly one cycle per accepted request.
- rsp_id  out  clog2(NREQ)  requester that owns the response.
- rsp_data  out  W  result; equals sh_out in the rsp_valid cycle.
- busy  out  1  high while any operation is in flight.

Behaviour:
- **Arbitration**
  - Combinational round-robin over req_valid, starting at index (last_grant+1) mod NREQ.
  - req_ready[i] = 1 only for the winning valid requester; all zero when no request is valid.
  - req_ready may depend combinationally on req_valid.
  - A transfer occurs when req_valid[i] && req_ready[i]. The block has no backpressure source, so one request is accepted every cycle in which any req_valid is high.
  - last_grant updates only on a transfer. Reset value is NREQ-1, so requester 0 has first priority after reset.
- **Issue register**
  - On a transfer at edge t, the sh_a, sh_shift and sh_rot registers load the winner's fields.
  - The registers hold their value on cycles without a transfer; the shifter result for those cycles is ignored.
  - Reset value of all three registers is 0.
- **Tag pipeline**
  - LAT+1 stages of {vld, id}. Stage 0 loads {transfer, winner_id} at each edge.
  - rsp_valid and rsp_id come from the last stage; rsp_data = sh_out (combinational pass).
  - Latency: a request accepted in cycle t produces rsp_valid in cycle t+1+LAT.
  - Responses are returned in acceptance order. Back-to-back accepts give back-to-back responses.
- **busy**: OR of all tag-stage vld bits.
- **Reset**
  - rst clears every vld bit and last_grant, and forces the issue registers to 0.
  - Operations in flight are discarded: no rsp_valid in any cycle after rst is sampled high, until a new accept.
  - req_ready is 0 while rst is high.
- **Boundary conditions**
  - shift = 0 returns a unchanged; shift = W-1 is legal.
  - Wrap-around of the grant pointer from NREQ-1 to 0 must be seamless.
  - A single active requester is granted every cycle.
  - Unused packed lanes of idle requesters are ignored.

Decomposition:
- Shared package `shifter_pkg`:
  - constants W=32, SW=5, LAT_DEFAULT=5, NREQ_DEFAULT=4;
  - a function for the id width (clog2(NREQ), minimum 1);
  - a packed struct typedef sh_op_t {a, shift, rot}.
- One sub-module, `rr_arbiter` (parameter N): inputs req[N] and an advance strobe; outputs a one-hot grant plus a binary grant_id; holds the last_grant pointer.
- The issue register and tag pipeline stay in the top module.

Test Plan:
1. **Single request**: requester 1 sends a=1, shift=1, rot=1 at cycle 10 → rsp_valid at cycle 16 (LAT=5), rsp_id=1, rsp_data=2; busy high for cycles 11–16.
2. **Rotate wrap vs. shift**:
   - a=0x80000000, shift=1, rot=1 → rsp_data=0x00000001.
   - The same operand with rot=0 → 0x00000000.
   - a=0xDEADBEEF, shift=0 → 0xDEADBEEF.
3. **Simultaneous requests**: all 4 req_valid rise together, and each drops after its accept → grants in cycles t..t+3 go to 0,1,2,3; responses in cycles t+6..t+9 carry ids 0,1,2,3 with the correct data.
4. **Fairness**: requesters 0 and 2 held valid continuously for 20 cycles → grants alternate 0,2,0,2…; each requester receives 10 accepts; none starve.
5. **Reset mid-flight**: 3 accepts, then rst asserted for 1 cycle two cycles later → no rsp_valid afterwards, busy=0 and req_ready=0 during rst, and the next accept goes to the lowest valid index.
6. **Streaming a single requester**: requester 3 alone, shift sweeping 1..31 with a=1, rot=1 → one accept per cycle and 31 consecutive responses, rsp_data = 1<<shift, rsp_id=3.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter arbitration slice.
//   W, SW           : data width and shift-amount width of the shared shifter
//   LAT_DEFAULT     : default shifter latency (sh_* inputs to valid sh_out)
//   NREQ_DEFAULT    : default number of requesters
//   id_w()          : requester-id width, never below 1 bit
//   sh_op_t         : one shifter operation {a, shift, rot}
package shifter_pkg;

  localparam int W            = 32;
  localparam int SW           = 5;
  localparam int LAT_DEFAULT  = 5;
  localparam int NREQ_DEFAULT = 4;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [W-1:0]  a;
    logic [SW-1:0] shift;
    logic          rot;
  } sh_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
//   clk, rst  : clock, synchronous active-high reset
//   req       : request vector
//   advance   : move the pointer to the current winner (asserted on a transfer)
//   grant     : one-hot winner, all zero when idle or in reset
//   grant_id  : binary index of the winner (0 when no grant)
module rr_arbiter
  import shifter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_w(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           advance,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] last_q;

  // Scan offsets from far to near so the nearest valid requester after
  // last_q is the final write and therefore the winner.
  always_comb begin
    logic [IDW-1:0] sel;
    sel      = '0;
    grant    = '0;
    grant_id = '0;
    if (!rst) begin
      for (int k = N; k >= 1; k--) begin
        sel = IDW'((int'(last_q) + k) % N);
        if (req[sel]) begin
          grant      = '0;
          grant[sel] = 1'b1;
          grant_id   = sel;
        end
      end
    end
  end

  // Pointer resets to N-1 so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (rst)          last_q <= IDW'(N - 1);
    else if (advance) last_q <= grant_id;
  end

endmodule

// File: rtl/shifter_arbiter.sv
// Shares one external pipelined barrel shifter among NREQ requesters.
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/req_ready        : per-requester handshake, ready one-hot or zero
//   req_a/req_shift/req_rot    : packed per-requester operands (lane i at [i*W +: W])
//   sh_a/sh_shift/sh_rot       : registered operation driven to the shifter
//   sh_out                     : shifter result, valid LAT cycles after sh_*
//   rsp_valid/rsp_id/rsp_data  : one response per accept, in acceptance order
//   busy                       : any operation in flight
module shifter_arbiter #(
  parameter  int NREQ = shifter_pkg::NREQ_DEFAULT,
  parameter  int W    = shifter_pkg::W,
  parameter  int SW   = shifter_pkg::SW,
  parameter  int LAT  = shifter_pkg::LAT_DEFAULT,
  localparam int IDW  = shifter_pkg::id_w(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*W-1:0]  req_a,
  input  logic [NREQ*SW-1:0] req_shift,
  input  logic [NREQ-1:0]    req_rot,
  output logic [W-1:0]       sh_a,
  output logic [SW-1:0]      sh_shift,
  output logic               sh_rot,
  input  logic [W-1:0]       sh_out,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_data,
  output logic               busy
);
  import shifter_pkg::*;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            xfer;
  sh_op_t          win_op, issue_q;

  // Stage 0 lines up with the issue register, stage LAT with sh_out.
  logic [LAT:0]          vld_pipe;
  logic [LAT:0][IDW-1:0] id_pipe;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .advance  (xfer),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Nothing downstream can stall, so any grant is a transfer.
  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    win_op       = '0;
    win_op.a     = req_a[grant_id*W +: W];
    win_op.shift = req_shift[grant_id*SW +: SW];
    win_op.rot   = req_rot[grant_id];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q  <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      if (xfer) issue_q <= win_op;
      vld_pipe <= {vld_pipe[LAT-1:0], xfer};
      id_pipe  <= {id_pipe[LAT-1:0], grant_id};
    end
  end

  assign sh_a     = issue_q.a;
  assign sh_shift = issue_q.shift;
  assign sh_rot   = issue_q.rot;

  assign rsp_valid = vld_pipe[LAT];
  assign rsp_id    = id_pipe[LAT];
  assign rsp_data  = sh_out;
  assign busy      = |vld_pipe;

endmodule

// File: tb/tb_shifter_arbiter.sv
module tb_shifter_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int SW   = 5;
  localparam int LAT  = 5;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*W-1:0]  req_a;
  logic [NREQ*SW-1:0] req_shift;
  logic [NREQ-1:0]    req_rot;
  logic [W-1:0]       sh_a;
  logic [SW-1:0]      sh_shift;
  logic               sh_rot;
  logic [W-1:0]       sh_out;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [W-1:0]       rsp_data;
  logic               busy;

  shifter_arbiter #(.NREQ(NREQ), .W(W), .SW(SW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_shift(req_shift), .req_rot(req_rot),
    .sh_a(sh_a), .sh_shift(sh_shift), .sh_rot(sh_rot), .sh_out(sh_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Environment: external shifter, LAT register stages, built bit by bit.
  logic [W-1:0] shp [LAT];
  always @(posedge clk) begin
    logic [W-1:0] v;
    v = sh_a;
    for (int i = 0; i < int'(sh_shift); i++)
      v = sh_rot ? {v[W-2:0], v[W-1]} : {v[W-2:0], 1'b0};
    shp[0] <= v;
    for (int i = 1; i < LAT; i++) shp[i] <= shp[i-1];
  end
  assign sh_out = shp[LAT-1];

  // Reference result from plain arithmetic on the request fields.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input int s, input logic r);
    logic [2*W-1:0] d;
    d = {a, a} << s;
    return r ? d[2*W-1:W] : (a << s);
  endfunction

  typedef struct { int due; int id; logic [W-1:0] data; } exp_t;
  exp_t exp_q[$];
  int   acc_log[$];
  int   acc_cnt[NREQ];
  int   mlast = NREQ - 1;
  int   cyc   = 0;
  bit   mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: round-robin winner, response timing/order, busy.
  always @(negedge clk) if (mon_en) begin
    logic [NREQ-1:0] exp_rdy;
    int win;
    chk("busy", busy, exp_q.size() > 0);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, exp_q[0].id);
      chk("rsp_data", rsp_data, exp_q[0].data);
      void'(exp_q.pop_front());
    end else begin
      chk("rsp_idle", rsp_valid, 0);
    end
    exp_rdy = '0;
    win = -1;
    if (!rst)
      for (int k = 1; k <= NREQ && win < 0; k++)
        if (req_valid[(mlast + k) % NREQ]) win = (mlast + k) % NREQ;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (rst) begin
      exp_q.delete();
      mlast = NREQ - 1;
    end else if (win >= 0) begin
      exp_t e;
      e.due  = cyc + 1 + LAT;
      e.id   = win;
      e.data = ref_op(req_a[win*W +: W], int'(req_shift[win*SW +: SW]), req_rot[win]);
      exp_q.push_back(e);
      mlast = win;
      acc_cnt[win]++;
      acc_log.push_back(win);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input int s, input logic r);
    req_a[i*W +: W]      = a;
    req_shift[i*SW +: SW] = SW'(s);
    req_rot[i]           = r;
  endtask

  task automatic scramble();
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom_range(0, 31), 1'($urandom));
  endtask

  initial begin
    int base, c0, c2;
    logic [NREQ-1:0] pend, seen;
    rst = 1'b1; req_valid = '0; req_a = '0; req_shift = '0; req_rot = '0;
    tick();
    mon_en = 1;
    tick(); tick();
    chk("rst_sh_a", sh_a, 0);
    chk("rst_sh_shift", sh_shift, 0);
    chk("rst_sh_rot", sh_rot, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single request from requester 1, then its busy window drains.
    scramble();
    set_op(1, 32'h1, 1, 1'b1); req_valid = 4'b0010; tick();
    req_valid = '0; repeat (LAT + 3) tick();

    // Rotate wrap, logical shift drop, zero shift.
    set_op(3, 32'h8000_0000, 1, 1'b1); req_valid = 4'b1000; tick();
    set_op(3, 32'h8000_0000, 1, 1'b0); tick();
    set_op(3, 32'hDEAD_BEEF, 0, 1'b1); tick();
    set_op(3, 32'hDEAD_BEEF, 31, 1'b1); tick();
    req_valid = '0; repeat (LAT + 3) tick();

    // All four at once, each drops after its own accept.
    scramble();
    base = acc_log.size();
    pend = '1;
    for (int n = 0; n < 8 && pend != 0; n++) begin
      req_valid = pend;
      @(negedge clk); seen = req_ready;
      tick();
      pend &= ~seen;
    end
    req_valid = '0;
    chk("simul_drained", pend, 0);
    for (int i = 0; i < NREQ; i++) chk("simul_order", acc_log[base + i], i);
    repeat (LAT + 3) tick();

    // Fairness between requesters 0 and 2.
    c0 = acc_cnt[0]; c2 = acc_cnt[2]; base = acc_log.size();
    req_valid = 4'b0101;
    repeat (20) begin scramble(); tick(); end
    req_valid = '0;
    chk("fair_r0", acc_cnt[0] - c0, 10);
    chk("fair_r2", acc_cnt[2] - c2, 10);
    chk("fair_alt", acc_log[base + 1], 2);
    repeat (LAT + 3) tick();

    // Reset with three operations in flight.
    req_valid = 4'b0010;
    repeat (3) begin scramble(); tick(); end
    req_valid = '0; tick(); tick();
    rst = 1'b1; req_valid = 4'b1111;
    @(negedge clk); chk("rst_ready", req_ready, 0);
    tick();
    rst = 1'b0; req_valid = 4'b1100;
    chk("post_rst_busy", busy, 0);
    @(negedge clk); chk("post_rst_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0; repeat (LAT + 3) tick();

    // Single requester streaming a shift sweep.
    c0 = acc_cnt[3];
    req_valid = 4'b1000;
    for (int s = 1; s <= 31; s++) begin scramble(); set_op(3, 32'h1, s, 1'b1); tick(); end
    req_valid = '0;
    chk("stream_accepts", acc_cnt[3] - c0, 31);
    repeat (LAT + 3) tick();

    // Random traffic with occasional reset pulses.
    repeat (300) begin
      scramble();
      req_valid = NREQ'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0; req_valid = '0;
    repeat (LAT + 4) tick();
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end

endmodule
